// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the multi-bus I2C slave responder.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned MAX_AW = 16;

    // Address answered on bus idx: base + idx, wrapped to aw bits.
    function automatic logic [MAX_AW-1:0] bus_addr(input logic [MAX_AW-1:0] base,
                                                   input logic [MAX_AW-1:0] idx,
                                                   input int unsigned       aw);
        logic [MAX_AW-1:0] mask;
        mask = MAX_AW'((32'd1 << aw) - 32'd1);
        return (base + idx) & mask;
    endfunction

endpackage

// File: rtl/i2c_edge_sync.sv
// Two-flop synchronizer plus START/STOP and SCL edge detector for one SCL/SDA pair.
module i2c_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic rise_q, fall_q, start_q, stop_q;
    logic rise_d, fall_d, start_d, stop_d;

    // Edge classification on the synchronized levels.
    always_comb begin
        rise_d  = scl_sync_q & ~scl_prev_q;
        fall_d  = ~scl_sync_q & scl_prev_q;
        start_d = scl_sync_q & scl_prev_q & ~sda_sync_q & sda_prev_q;
        stop_d  = scl_sync_q & scl_prev_q & sda_sync_q & ~sda_prev_q;
    end

    // Synchronizer chain and registered event strobes; idle bus levels on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // sda_prev_q holds the SDA level seen by the strobes currently presented.
    assign sda_lvl_o  = sda_prev_q;
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_mb_slave_array.sv
// I2C slave responder serving one selectable bus of an N-bus fabric, backed by a byte register file.
module i2c_mb_slave_array
    import i2c_slave_pkg::*;
#(
    parameter int unsigned NUM_BUSSES = 16,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h22
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_BUSSES-1:0]         scl_i,
    input  logic [NUM_BUSSES-1:0]         sda_i,
    output logic [NUM_BUSSES-1:0]         sda_o,
    input  logic [$clog2(NUM_BUSSES)-1:0] bus_sel_i,
    output logic                          busy_o,
    output logic                          xfer_done_o,
    output logic                          xfer_rw_o,
    output logic [DATA_WIDTH-1:0]         xfer_cnt_o
);

    localparam int unsigned BW = $clog2(NUM_BUSSES);
    localparam int unsigned PW = $clog2(MEM_DEPTH);
    localparam int unsigned SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int unsigned CW = $clog2(SW + 1);

    state_e                  state_q, state_d;
    logic [BW-1:0]           bus_q, bus_d;
    logic [SW-1:0]           sh_q, sh_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    drv_q, drv_d;
    logic                    rw_q, rw_d;
    logic                    match_q, match_d;
    logic [DATA_WIDTH-1:0]   bytes_q, bytes_d;
    logic [NUM_BUSSES-1:0]   sda_o_q, sda_o_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    xrw_q, xrw_d;
    logic [DATA_WIDTH-1:0]   xcnt_q, xcnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    sda_s, scl_rise, scl_fall, start_s, stop_s;
    logic [SW-1:0]           shifted;
    logic [ADDR_WIDTH-1:0]   my_addr;
    logic [DATA_WIDTH-1:0]   rd_bits;

    // Single detector placed after the bus mux.
    i2c_edge_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i[bus_q]),
        .sda_i      (sda_i[bus_q]),
        .sda_lvl_o  (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    assign shifted = {sh_q[SW-2:0], sda_s};
    assign my_addr = ADDR_WIDTH'(bus_addr(MAX_AW'(BASE_ADDR), MAX_AW'(bus_q), ADDR_WIDTH));
    assign rd_bits = mem_q[ptr_q] << cnt_q;

    // Protocol FSM: next state, drive level, pointer and transfer bookkeeping.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        drv_d     = drv_q;
        rw_d      = rw_q;
        match_d   = match_q;
        bytes_d   = bytes_q;
        xrw_d     = xrw_q;
        xcnt_d    = xcnt_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = shifted[DATA_WIDTH-1:0];

        if (stop_s) begin
            // STOP wins over a simultaneous START glitch.
            state_d = ST_IDLE;
            drv_d   = NACK;
            match_d = 1'b0;
            if (match_q) begin
                done_d = 1'b1;
                xrw_d  = rw_q;
                xcnt_d = bytes_q;
            end
        end else if (start_s) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            drv_d   = NACK;
            if (state_q == ST_IDLE) begin
                bytes_d = '0;
                match_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bus_d = bus_sel_i;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(ADDR_WIDTH)) begin
                            if (shifted[ADDR_WIDTH:1] == my_addr) begin
                                match_d = 1'b1;
                                rw_d    = shifted[0];
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall starts the ACK bit, second fall ends it.
                    if (scl_fall) begin
                        if (drv_q) begin
                            drv_d = ACK;
                        end else begin
                            cnt_d = '0;
                            if (rw_q) begin
                                state_d = ST_RDATA;
                                drv_d   = mem_q[ptr_q][DATA_WIDTH-1];
                            end else begin
                                state_d = ST_PTR;
                                drv_d   = NACK;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            ptr_d   = PW'(shifted[DATA_WIDTH-1:0]);
                            state_d = ST_PTR_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_q + PW'(1);
                            bytes_d = (&bytes_q) ? bytes_q : bytes_q + DATA_WIDTH'(1);
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (drv_q) begin
                            drv_d = ACK;
                        end else begin
                            drv_d   = NACK;
                            cnt_d   = '0;
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (scl_fall) begin
                        if (cnt_q == CW'(DATA_WIDTH)) begin
                            drv_d   = NACK;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            drv_d = rd_bits[DATA_WIDTH-1];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_d   = ptr_q + PW'(1);
                        bytes_d = (&bytes_q) ? bytes_q : bytes_q + DATA_WIDTH'(1);
                        cnt_d   = '0;
                        state_d = (sda_s == ACK) ? ST_RDATA : ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    drv_d = NACK;
                end
                default: begin
                    state_d = ST_IDLE;
                    drv_d   = NACK;
                end
            endcase
        end

        sda_o_d        = '1;
        sda_o_d[bus_d] = drv_d;
        busy_d         = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            drv_q   <= 1'b1;
            rw_q    <= 1'b0;
            match_q <= 1'b0;
            bytes_q <= '0;
            sda_o_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            xrw_q   <= 1'b0;
            xcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            drv_q   <= drv_d;
            rw_q    <= rw_d;
            match_q <= match_d;
            bytes_q <= bytes_d;
            sda_o_q <= sda_o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            xrw_q   <= xrw_d;
            xcnt_q  <= xcnt_d;
        end
    end

    // Register file, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    assign sda_o       = sda_o_q;
    assign busy_o      = busy_q;
    assign xfer_done_o = done_q;
    assign xfer_rw_o   = xrw_q;
    assign xfer_cnt_o  = xcnt_q;

endmodule
